// File: rtl/osc_burst_sequencer.sv
// osc_burst_sequencer
//
// Burst controller for the 8-bit sine/cosine recurrence oscillator. An
// accepted start re-seeds the oscillator (one cycle of osc_rst_n low), then
// for each of burst_len samples waits div cycles, steps the oscillator once
// (osc_en) while capturing its next-value outputs, and offers the captured
// pair on a valid/ready sample port. Rising zero-crossings of the captured
// sine are counted per burst in period_cnt (saturating).
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   start, abort      burst request (IDLE only), synchronous cancel
//   burst_len, div    samples per burst, wait cycles per step (latched on start)
//   busy, done        not-IDLE flag, 1-cycle completion pulse
//   osc_en, osc_rst_n oscillator step enable and active-low re-seed
//   sine_in, cos_in   oscillator combinational next-value outputs
//   smp_valid/ready   sample handshake
//   smp_sine/cos/idx  captured sample and its 0-based index
//   smp_last          decoded: valid sample is the final one of the burst
//   period_cnt        rising zero-crossings seen this burst
//   state_dbg         current FSM state encoding, for observation only
//
// Handshake: a sample transfers on every clock edge where smp_valid and
// smp_ready are both high. Once smp_valid rises, smp_sine/smp_cos/smp_idx/
// smp_last hold steady until that transfer; only abort or reset may retract
// smp_valid before it.

module osc_burst_sequencer #(
  parameter int LEN_W  = 8,
  parameter int DIV_W  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic [DIV_W-1:0]  div,
  output logic              busy,
  output logic              done,
  output logic              osc_en,
  output logic              osc_rst_n,
  input  logic [DATA_W-1:0] sine_in,
  input  logic [DATA_W-1:0] cos_in,
  output logic              smp_valid,
  input  logic              smp_ready,
  output logic [DATA_W-1:0] smp_sine,
  output logic [DATA_W-1:0] smp_cos,
  output logic [LEN_W-1:0]  smp_idx,
  output logic              smp_last,
  output logic [LEN_W-1:0]  period_cnt,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RESTART = 3'd1,
    S_WAIT    = 3'd2,
    S_STEP    = 3'd3,
    S_OUT     = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  state_t              state_q,     state_d;
  logic [LEN_W-1:0]    len_q,       len_d;
  logic [DIV_W-1:0]    div_q,       div_d;
  logic [DIV_W-1:0]    wait_q,      wait_d;
  logic [LEN_W-1:0]    idx_q,       idx_d;
  logic [LEN_W-1:0]    period_q,    period_d;
  logic                first_q,     first_d;
  logic [DATA_W-1:0]   sine_q,      sine_d;
  logic [DATA_W-1:0]   cos_q,       cos_d;
  logic                busy_q,      busy_d;
  logic                done_q,      done_d;
  logic                osc_en_q,    osc_en_d;
  logic                osc_rst_n_q, osc_rst_n_d;
  logic                valid_q,     valid_d;

  logic                is_last;
  logic                zero_cross;

  assign is_last = (idx_q == (len_q - LEN_ONE));

  // A rising crossing needs a predecessor in this burst: first_q marks the
  // capture that has none, so its comparison against a stale sine_q is void.
  assign zero_cross = !first_q && sine_q[DATA_W-1] && !sine_in[DATA_W-1];

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    div_d    = div_q;
    wait_d   = wait_q;
    idx_d    = idx_q;
    period_d = period_q;
    first_d  = first_q;
    sine_d   = sine_q;
    cos_d    = cos_q;

    case (state_q)
      S_IDLE: begin
        // A zero-length request is dropped silently: no burst, no done.
        if (start && !abort && (burst_len != '0)) begin
          len_d    = burst_len;
          div_d    = div;
          idx_d    = '0;
          period_d = '0;
          first_d  = 1'b1;
          state_d  = S_RESTART;
        end
      end

      S_RESTART: begin
        if (div_q != '0) begin
          wait_d  = div_q;
          state_d = S_WAIT;
        end else begin
          state_d = S_STEP;
        end
      end

      S_WAIT: begin
        // wait_q is loaded with div on entry, so hitting 1 means this is
        // the div-th wait cycle.
        if (wait_q == DIV_ONE) begin
          state_d = S_STEP;
        end else begin
          wait_d = wait_q - DIV_ONE;
        end
      end

      S_STEP: begin
        // osc_en is high this cycle; the oscillator advances on the same
        // edge that captures its next-value outputs.
        sine_d  = sine_in;
        cos_d   = cos_in;
        first_d = 1'b0;
        if (zero_cross && (period_q != '1)) begin
          period_d = period_q + LEN_ONE;
        end
        state_d = S_OUT;
      end

      S_OUT: begin
        if (smp_ready) begin
          if (is_last) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + LEN_ONE;
            if (div_q != '0) begin
              wait_d  = div_q;
              state_d = S_WAIT;
            end else begin
              state_d = S_STEP;
            end
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort beats any handshake, capture or start in the same cycle and
    // freezes the index, counter and sample registers where they are.
    if (abort && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      idx_d    = idx_q;
      period_d = period_q;
      first_d  = first_q;
      sine_d   = sine_q;
      cos_d    = cos_q;
    end

    // Registered outputs are decoded from the next state so each one is
    // exactly aligned with the state it describes.
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    osc_en_d    = (state_d == S_STEP);
    osc_rst_n_d = (state_d != S_RESTART);
    valid_d     = (state_d == S_OUT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      div_q       <= '0;
      wait_q      <= '0;
      idx_q       <= '0;
      period_q    <= '0;
      first_q     <= 1'b0;
      sine_q      <= '0;
      cos_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      osc_en_q    <= 1'b0;
      osc_rst_n_q <= 1'b1;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      div_q       <= div_d;
      wait_q      <= wait_d;
      idx_q       <= idx_d;
      period_q    <= period_d;
      first_q     <= first_d;
      sine_q      <= sine_d;
      cos_q       <= cos_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      osc_en_q    <= osc_en_d;
      osc_rst_n_q <= osc_rst_n_d;
      valid_q     <= valid_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign osc_en     = osc_en_q;
  assign osc_rst_n  = osc_rst_n_q;
  assign smp_valid  = valid_q;
  assign smp_sine   = sine_q;
  assign smp_cos    = cos_q;
  assign smp_idx    = idx_q;
  assign smp_last   = (state_q == S_OUT) && is_last;
  assign period_cnt = period_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_osc_burst_sequencer.sv
// Bench for osc_burst_sequencer. A behavioural oscillator (rounded
// 120*sin/cos at 0.125 rad per step, re-seeded to phase 0) feeds the DUT.
// Expected samples, indices, timing and zero-crossing counts come from that
// phase model and the burst rules, not from the DUT.

module tb_osc_burst_sequencer;
  localparam int LEN_W  = 8;
  localparam int DIV_W  = 4;
  localparam int DATA_W = 8;
  localparam int BUDGET = 3000;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              abort;
  logic [LEN_W-1:0]  burst_len;
  logic [DIV_W-1:0]  div;
  logic              busy, done, osc_en, osc_rst_n;
  logic [DATA_W-1:0] sine_in, cos_in;
  logic              smp_valid, smp_ready, smp_last;
  logic [DATA_W-1:0] smp_sine, smp_cos;
  logic [LEN_W-1:0]  smp_idx, period_cnt;
  logic [2:0]        state_dbg;

  always #5 clk = ~clk;

  osc_burst_sequencer #(.LEN_W(LEN_W), .DIV_W(DIV_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .burst_len(burst_len), .div(div), .busy(busy), .done(done),
    .osc_en(osc_en), .osc_rst_n(osc_rst_n), .sine_in(sine_in), .cos_in(cos_in),
    .smp_valid(smp_valid), .smp_ready(smp_ready), .smp_sine(smp_sine),
    .smp_cos(smp_cos), .smp_idx(smp_idx), .smp_last(smp_last),
    .period_cnt(period_cnt), .state_dbg(state_dbg)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- oscillator model ----------------
  function automatic logic [DATA_W-1:0] osc_val(input int n, input bit is_cos);
    real r;
    int  v;
    r = 120.0 * (is_cos ? $cos(0.125 * n) : $sin(0.125 * n));
    if (r >= 0.0) v = $rtoi(r + 0.5);
    else          v = -$rtoi(0.5 - r);
    return v[DATA_W-1:0];
  endfunction

  int osc_n = 0;
  always @(posedge clk) begin
    if (!osc_rst_n)  osc_n <= 0;
    else if (osc_en) osc_n <= osc_n + 1;
  end
  always_comb begin
    sine_in = osc_val(osc_n + 1, 1'b0);
    cos_in  = osc_val(osc_n + 1, 1'b1);
  end

  // Sample k of a burst is oscillator phase k+1; count sign changes - to +.
  function automatic int exp_periods(input int len);
    int c = 0;
    logic [DATA_W-1:0] a, b;
    for (int k = 1; k < len; k++) begin
      a = osc_val(k, 1'b0);
      b = osc_val(k + 1, 1'b0);
      if (a[DATA_W-1] && !b[DATA_W-1] && c < 255) c++;
    end
    return c;
  endfunction

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] obs_sine[$];
  logic [DATA_W-1:0] obs_cos[$];
  logic [LEN_W-1:0]  obs_idx[$];
  bit                obs_last[$];
  int                obs_vcyc[$];
  int                obs_hcyc[$];
  int obs_acc, obs_done_cnt, obs_done_cyc, obs_en_cnt, obs_bad_en, obs_bad_hold, obs_busy_cnt;
  bit obs_busy_at_done, obs_timeout;
  logic [LEN_W-1:0] obs_period_first, obs_period_end;

  // ---------------- driver ----------------
  // Runs one burst and records what the sample port did. obs_acc is the
  // RESTART cycle (spec cycle t+1). stall0 holds ready low for that many
  // valid cycles of sample 0; otherwise ready is low with stall_pct odds.
  task automatic run_burst(input int len, input int dv, input int stall_pct, input int stall0);
    bit in_smp = 0, seen_done = 0, fin = 0;
    int held = 0, k = 0;
    obs_sine.delete(); obs_cos.delete(); obs_idx.delete(); obs_last.delete();
    obs_vcyc.delete(); obs_hcyc.delete();
    obs_done_cnt = 0; obs_done_cyc = -1; obs_en_cnt = 0; obs_bad_en = 0;
    obs_bad_hold = 0; obs_busy_cnt = 0; obs_busy_at_done = 0; obs_timeout = 0;
    @(posedge clk); #1;
    burst_len = len[LEN_W-1:0]; div = dv[DIV_W-1:0]; start = 1'b1; abort = 1'b0;
    smp_ready = (stall0 > 0) ? 1'b0 : ($urandom_range(99) >= stall_pct);
    @(posedge clk); #1;
    obs_acc = cyc;
    start = 1'b0;
    burst_len = LEN_W'($urandom_range(1, 255));
    div = DIV_W'($urandom_range(15));
    while (!fin && k < BUDGET) begin
      @(negedge clk);
      if (k == 0) obs_period_first = period_cnt;
      if (busy) obs_busy_cnt++;
      if (osc_en) obs_en_cnt++;
      if (osc_en && (!osc_rst_n || smp_valid)) obs_bad_en++;
      if (done) begin
        obs_done_cnt++; obs_done_cyc = cyc; obs_busy_at_done = busy; seen_done = 1;
      end
      if (smp_valid) begin
        if (!in_smp) begin
          obs_sine.push_back(smp_sine); obs_cos.push_back(smp_cos);
          obs_idx.push_back(smp_idx); obs_last.push_back(smp_last);
          obs_vcyc.push_back(cyc); in_smp = 1; held = 0;
        end else if (smp_sine !== obs_sine[$] || smp_cos !== obs_cos[$] ||
                     smp_idx !== obs_idx[$] || smp_last !== obs_last[$]) begin
          obs_bad_hold++;
        end
        held++;
        if (smp_ready) begin obs_hcyc.push_back(cyc); in_smp = 0; end
      end else begin
        in_smp = 0;
      end
      if (seen_done && !busy) begin
        fin = 1;
      end else begin
        @(posedge clk); #1;
        start = (busy && !done) ? 1'($urandom_range(1)) : 1'b0;
        burst_len = LEN_W'($urandom_range(1, 255));
        div = DIV_W'($urandom_range(15));
        if (stall0 > 0 && obs_hcyc.size() == 0 && held < stall0) smp_ready = 1'b0;
        else smp_ready = ($urandom_range(99) >= stall_pct);
      end
      k++;
    end
    start = 1'b0;
    obs_timeout = !fin;
    obs_period_end = period_cnt;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; smp_ready = 1'b0;
    burst_len = '0; div = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy, done, osc_en, smp_valid, smp_last, osc_rst_n} !== 6'b000001) begin
      n_fail++;
      $display("FAIL reset_flags got %b exp 000001", {busy, done, osc_en, smp_valid, smp_last, osc_rst_n});
    end
    n_checks++;
    if ({smp_sine, smp_cos, smp_idx, period_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_data got %h/%h/%h/%h exp 0", smp_sine, smp_cos, smp_idx, period_cnt);
    end
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [DATA_W-1:0] es[3] = '{8'd15, 8'd30, 8'd44};
    logic [DATA_W-1:0] ec[3] = '{8'd119, 8'd116, 8'd112};
    run_burst(3, 0, 0, 0);
    n_checks++;
    if (obs_timeout || obs_sine.size() != 3) begin
      n_fail++; $display("FAIL basic_count got %0d samples timeout=%0d exp 3", obs_sine.size(), obs_timeout);
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (obs_sine[k] !== es[k] || obs_cos[k] !== ec[k] || obs_idx[k] !== LEN_W'(k) || obs_last[k] !== (k == 2)) begin
          n_fail++;
          $display("FAIL basic_sample k=%0d got (%0d,%0d) idx %0d last %0d exp (%0d,%0d) idx %0d last %0d",
                   k, obs_sine[k], obs_cos[k], obs_idx[k], obs_last[k], es[k], ec[k], k, k == 2);
        end
      end
      n_checks++;
      if (obs_vcyc[0] !== obs_acc + 2) begin
        n_fail++; $display("FAIL basic_first_valid got cycle %0d exp %0d", obs_vcyc[0], obs_acc + 2);
      end
      n_checks++;
      if (obs_done_cnt !== 1 || obs_done_cyc !== obs_hcyc[2] + 1 || !obs_busy_at_done) begin
        n_fail++;
        $display("FAIL basic_done got cnt %0d cyc %0d busy %0d exp 1 %0d 1", obs_done_cnt, obs_done_cyc, obs_busy_at_done, obs_hcyc[2] + 1);
      end
    end
  endtask

  task automatic test_divided();
    run_burst(4, 3, 0, 0);
    n_checks++;
    if (obs_timeout || obs_vcyc.size() != 4) begin
      n_fail++; $display("FAIL div_count got %0d samples timeout=%0d exp 4", obs_vcyc.size(), obs_timeout);
    end else begin
      n_checks++;
      if (obs_vcyc[0] !== obs_acc + 5) begin
        n_fail++; $display("FAIL div_first_valid got %0d exp %0d", obs_vcyc[0], obs_acc + 5);
      end
      for (int k = 1; k < 4; k++) begin
        n_checks++;
        if (obs_vcyc[k] - obs_vcyc[k-1] !== 5) begin
          n_fail++; $display("FAIL div_period k=%0d got %0d exp 5", k, obs_vcyc[k] - obs_vcyc[k-1]);
        end
      end
    end
    n_checks++;
    if (obs_en_cnt !== 4) begin
      n_fail++; $display("FAIL div_osc_en got %0d exp 4", obs_en_cnt);
    end
    n_checks++;
    if (obs_busy_cnt !== 2 + 4 * 5) begin
      n_fail++; $display("FAIL div_burst_len got %0d busy cycles exp %0d", obs_busy_cnt, 2 + 4 * 5);
    end
  endtask

  task automatic test_backpressure();
    run_burst(2, 0, 0, 7);
    n_checks++;
    if (obs_timeout || obs_hcyc.size() != 2) begin
      n_fail++; $display("FAIL bp_count got %0d handshakes timeout=%0d exp 2", obs_hcyc.size(), obs_timeout);
    end else begin
      n_checks++;
      if (obs_hcyc[0] - obs_vcyc[0] !== 7) begin
        n_fail++; $display("FAIL bp_stall got %0d cycles exp 7", obs_hcyc[0] - obs_vcyc[0]);
      end
      n_checks++;
      if (obs_sine[0] !== 8'd15 || obs_cos[0] !== 8'd119 || obs_sine[1] !== 8'd30 || obs_cos[1] !== 8'd116) begin
        n_fail++;
        $display("FAIL bp_values got (%0d,%0d)(%0d,%0d) exp (15,119)(30,116)", obs_sine[0], obs_cos[0], obs_sine[1], obs_cos[1]);
      end
      n_checks++;
      if (obs_vcyc[1] !== obs_hcyc[0] + 2) begin
        n_fail++; $display("FAIL bp_resume got %0d exp %0d", obs_vcyc[1], obs_hcyc[0] + 2);
      end
    end
    n_checks++;
    if (obs_bad_hold !== 0 || obs_bad_en !== 0 || obs_en_cnt !== 2) begin
      n_fail++; $display("FAIL bp_hold got hold %0d en %0d en_cnt %0d exp 0 0 2", obs_bad_hold, obs_bad_en, obs_en_cnt);
    end
  endtask

  task automatic test_period();
    run_burst(60, 0, 30, 0);
    n_checks++;
    if (obs_timeout || obs_period_end !== LEN_W'(1) || exp_periods(60) != 1) begin
      n_fail++;
      $display("FAIL period_60 got %0d timeout=%0d exp 1 (model %0d)", obs_period_end, obs_timeout, exp_periods(60));
    end
    for (int k = 0; k < obs_sine.size() && k < 60; k++) begin
      n_checks++;
      if (obs_sine[k] !== osc_val(k + 1, 1'b0) || obs_cos[k] !== osc_val(k + 1, 1'b1)) begin
        n_fail++;
        $display("FAIL period_sample k=%0d got (%0d,%0d) exp (%0d,%0d)", k, obs_sine[k], obs_cos[k], osc_val(k + 1, 1'b0), osc_val(k + 1, 1'b1));
      end
    end
    run_burst(2, 0, 0, 0);
    n_checks++;
    if (obs_period_first !== '0 || obs_sine.size() == 0) begin
      n_fail++; $display("FAIL period_clear got %0d samples %0d exp 0", obs_period_first, obs_sine.size());
    end else begin
      n_checks++;
      if (obs_sine[0] !== 8'd15 || obs_cos[0] !== 8'd119) begin
        n_fail++; $display("FAIL period_restart got (%0d,%0d) exp (15,119)", obs_sine[0], obs_cos[0]);
      end
    end
  endtask

  task automatic test_abort();
    bit found = 0;
    int saw_busy = 0, saw_done = 0;
    @(posedge clk); #1;
    burst_len = 8'd5; div = DIV_W'($urandom_range(3)); start = 1'b1; abort = 1'b0; smp_ready = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (smp_valid && smp_idx == 1) found = 1;
      else begin
        @(posedge clk); #1 smp_ready = smp_valid && (smp_idx == 0);
      end
    end
    n_checks++;
    if (!found) begin
      n_fail++; $display("FAIL abort_reach got no idx=1 sample exp one within 200 cycles");
    end else begin
      // abort and a handshake in the same cycle: abort wins
      @(posedge clk); #1 abort = 1'b1; smp_ready = 1'b1;
      @(posedge clk); #1 abort = 1'b0; smp_ready = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({busy, smp_valid, done, smp_last} !== 4'b0000) begin
        n_fail++; $display("FAIL abort_idle got busy/valid/done/last %b exp 0000", {busy, smp_valid, done, smp_last});
      end
      n_checks++;
      if (smp_idx !== LEN_W'(1) || period_cnt !== LEN_W'(exp_periods(2))) begin
        n_fail++; $display("FAIL abort_hold got idx %0d period %0d exp 1 %0d", smp_idx, period_cnt, exp_periods(2));
      end
      repeat (6) begin
        @(negedge clk);
        if (done) saw_done++;
      end
      n_checks++;
      if (saw_done != 0) begin
        n_fail++; $display("FAIL abort_no_done got %0d pulses exp 0", saw_done);
      end
    end
    @(posedge clk); #1 burst_len = '0; div = DIV_W'($urandom_range(15)); start = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (busy || done) saw_busy++;
    end
    start = 1'b0;
    n_checks++;
    if (saw_busy != 0) begin
      n_fail++; $display("FAIL zero_len got %0d busy/done cycles exp 0", saw_busy);
    end
  endtask

  task automatic test_reset_midburst();
    @(posedge clk); #1 burst_len = 8'd4; div = 4'd5; start = 1'b1; smp_ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    n_checks++;
    if (busy !== 1'b1 || smp_valid !== 1'b0 || osc_en !== 1'b0) begin
      n_fail++; $display("FAIL midrst_wait got busy %0d valid %0d en %0d exp 1 0 0", busy, smp_valid, osc_en);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, osc_en, smp_valid, smp_last, osc_rst_n} !== 6'b000001 ||
        {smp_sine, smp_cos, smp_idx, period_cnt} !== '0) begin
      n_fail++;
      $display("FAIL midrst_values got %b %h/%h/%h/%h exp 000001 0", {busy, done, osc_en, smp_valid, smp_last, osc_rst_n},
               smp_sine, smp_cos, smp_idx, period_cnt);
    end
    @(posedge clk); #1 reset = 1'b0;
    run_burst(2, 0, 0, 0);
    n_checks++;
    if (obs_timeout || obs_sine.size() == 0 || obs_sine[0] !== 8'd15 || obs_cos[0] !== 8'd119) begin
      n_fail++; $display("FAIL midrst_restart got %0d samples timeout=%0d exp first (15,119)", obs_sine.size(), obs_timeout);
    end
  endtask

  task automatic test_random();
    int len, dv, sp;
    for (int it = 0; it < 8; it++) begin
      len = $urandom_range(1, 12);
      dv  = $urandom_range(0, 4);
      sp  = (it < 2) ? 0 : $urandom_range(0, 60);
      run_burst(len, dv, sp, 0);
      n_checks++;
      if (obs_timeout || obs_sine.size() != len || obs_hcyc.size() != len) begin
        n_fail++;
        $display("FAIL rnd_count it=%0d got %0d/%0d timeout=%0d exp %0d", it, obs_sine.size(), obs_hcyc.size(), obs_timeout, len);
        continue;
      end
      for (int k = 0; k < len; k++) begin
        n_checks++;
        if (obs_sine[k] !== osc_val(k + 1, 1'b0) || obs_cos[k] !== osc_val(k + 1, 1'b1) ||
            obs_idx[k] !== LEN_W'(k) || obs_last[k] !== (k == len - 1)) begin
          n_fail++;
          $display("FAIL rnd_sample it=%0d k=%0d got (%0d,%0d) idx %0d last %0d exp (%0d,%0d)", it, k,
                   obs_sine[k], obs_cos[k], obs_idx[k], obs_last[k], osc_val(k + 1, 1'b0), osc_val(k + 1, 1'b1));
        end
        n_checks++;
        if (obs_vcyc[k] !== ((k == 0) ? obs_acc + 2 + dv : obs_hcyc[k-1] + dv + 2)) begin
          n_fail++; $display("FAIL rnd_timing it=%0d k=%0d got valid at %0d", it, k, obs_vcyc[k]);
        end
      end
      n_checks++;
      if (obs_done_cnt !== 1 || obs_done_cyc !== obs_hcyc[len-1] + 1 || !obs_busy_at_done) begin
        n_fail++; $display("FAIL rnd_done it=%0d got cnt %0d cyc %0d exp 1 %0d", it, obs_done_cnt, obs_done_cyc, obs_hcyc[len-1] + 1);
      end
      n_checks++;
      if (obs_en_cnt !== len || obs_bad_en !== 0 || obs_bad_hold !== 0) begin
        n_fail++; $display("FAIL rnd_osc it=%0d got en %0d bad_en %0d bad_hold %0d exp %0d 0 0", it, obs_en_cnt, obs_bad_en, obs_bad_hold, len);
      end
      n_checks++;
      if (obs_period_end !== LEN_W'(exp_periods(len))) begin
        n_fail++; $display("FAIL rnd_period it=%0d got %0d exp %0d", it, obs_period_end, exp_periods(len));
      end
      if (sp == 0) begin
        n_checks++;
        if (obs_busy_cnt !== 2 + len * (dv + 2)) begin
          n_fail++; $display("FAIL rnd_busy it=%0d got %0d exp %0d", it, obs_busy_cnt, 2 + len * (dv + 2));
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_divided();
    test_backpressure();
    test_period();
    test_abort();
    test_reset_midburst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
